// File: rtl/ssd_display_arbiter_if.sv
// Requester/display bundle for the shared seven-segment display arbiter.
// The master side drives requests and values; the slave side drives the display.
interface ssd_display_arbiter_if;
   logic [2:0]  req;
   logic [13:0] val0;
   logic [13:0] val1;
   logic [13:0] val2;
   logic [2:0]  grant;
   logic        busy;
   logic [3:0]  activate;
   logic [6:0]  LED_output;

   modport master (
      output req, val0, val1, val2,
      input  grant, busy, activate, LED_output
   );

   modport slave (
      input  req, val0, val1, val2,
      output grant, busy, activate, LED_output
   );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Round-robin owner of a 4-digit seven-segment display with minimum hold,
// sequential double-dabble conversion and registered anode/segment scan.
module ssd_display_arbiter #(
   parameter int TICK_DIV   = 100000,
   parameter int HOLD_TICKS = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   ssd_display_arbiter_if.slave bus
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

   state_t        r_state, w_next;
   logic [TW-1:0] r_tick_cnt;
   logic [HW-1:0] r_hold_cnt;
   logic [1:0]    r_last_ptr;
   logic [2:0]    r_grant;
   logic [13:0]   r_hold_val;
   logic [13:0]   r_bin;
   logic [15:0]   r_bcd;
   logic [3:0]    r_step;
   logic [15:0]   r_digits;
   logic          r_ovf;
   logic [1:0]    r_idx;
   logic [3:0]    r_act;
   logic [6:0]    r_led;

   logic          w_tick, w_hold_done, w_holder_req, w_others;
   logic          w_load, w_commit, w_drop, w_ovf_nxt;
   logic [1:0]    w_c1, w_c2, w_sel, w_mux_idx, w_idx_nxt;
   logic [13:0]   w_mux_val, w_bin_nxt;
   logic [15:0]   w_adj, w_bcd_nxt, w_dig_nxt;
   logic [3:0]    w_nib;

   function automatic logic [1:0] inc3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [6:0] seg(input logic [3:0] d);
      unique case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0011000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign w_tick       = (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_hold_done  = (r_hold_cnt == HW'(HOLD_TICKS));
   assign w_holder_req = bus.req[r_last_ptr];
   assign w_others     = |(bus.req & ~r_grant);

   // Cyclic search starting just after the last winner
   assign w_c1  = inc3(r_last_ptr);
   assign w_c2  = inc3(w_c1);
   assign w_sel = bus.req[w_c1] ? w_c1 :
                  bus.req[w_c2] ? w_c2 : r_last_ptr;

   assign w_mux_idx = (r_state == IDLE) ? w_sel : r_last_ptr;

   always_comb begin
      w_mux_val = bus.val2;
      unique case (w_mux_idx)
         2'd0:    w_mux_val = bus.val0;
         2'd1:    w_mux_val = bus.val1;
         default: w_mux_val = bus.val2;
      endcase
   end

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 4; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
      {w_bcd_nxt, w_bin_nxt} = {w_adj[14:0], r_bin, 1'b0};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (|bus.req) w_next = CONVERT;
         CONVERT: if (r_step == 4'd13) w_next = SHOW;
         SHOW: begin
            if (!w_holder_req)    w_next = IDLE;
            else if (w_hold_done) w_next = w_others ? IDLE : CONVERT;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (r_state == CONVERT);
      bus.grant = r_grant;
      w_commit  = (r_state == CONVERT) && (r_step == 4'd13);
      w_drop    = (r_state == SHOW) && (w_next == IDLE);
      w_load    = ((r_state == IDLE) && (|bus.req)) ||
                  ((r_state == SHOW) && (w_next == CONVERT));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
         if (w_commit)
            r_hold_cnt <= '0;
         else if ((r_state == SHOW) && w_tick && !w_hold_done)
            r_hold_cnt <= r_hold_cnt + HW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_ptr <= 2'd2;
         r_grant    <= '0;
         r_hold_val <= '0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_step     <= '0;
         r_digits   <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_load) begin
            r_hold_val <= w_mux_val;
            r_bin      <= w_mux_val;
            r_bcd      <= '0;
            r_step     <= '0;
            r_grant    <= 3'b001 << w_mux_idx;
            r_last_ptr <= w_mux_idx;
         end else if (r_state == CONVERT) begin
            r_bin  <= w_bin_nxt;
            r_bcd  <= w_bcd_nxt;
            r_step <= r_step + 4'd1;
         end
         if (w_drop)
            r_grant <= '0;
         if (w_commit) begin
            r_digits <= w_bcd_nxt;
            r_ovf    <= (r_hold_val > 14'd9999);
         end
      end
   end

   // Outputs are registered from next-state values so commit and scan line up
   assign w_idx_nxt = w_tick ? r_idx + 2'd1 : r_idx;
   assign w_dig_nxt = w_commit ? w_bcd_nxt : r_digits;
   assign w_ovf_nxt = w_commit ? (r_hold_val > 14'd9999) : r_ovf;

   always_comb begin
      w_nib = w_dig_nxt[15:12];
      unique case (w_idx_nxt)
         2'd0: w_nib = w_dig_nxt[15:12];
         2'd1: w_nib = w_dig_nxt[11:8];
         2'd2: w_nib = w_dig_nxt[7:4];
         2'd3: w_nib = w_dig_nxt[3:0];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx <= '0;
         r_act <= 4'b0111;
         r_led <= 7'b1000000;
      end else begin
         r_idx <= w_idx_nxt;
         r_act <= ~(4'b1000 >> w_idx_nxt);
         r_led <= w_ovf_nxt ? 7'b0111111 : seg(w_nib);
      end
   end

   assign bus.activate   = r_act;
   assign bus.LED_output = r_led;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed bench for the display arbiter, run with short tick and hold
// periods so arbitration, conversion and scan are all reachable quickly.
module tb_ssd_display_arbiter;

   localparam int TD = 4;
   localparam int HT = 4;

   localparam logic [6:0] S0   = 7'b1000000;
   localparam logic [6:0] S1   = 7'b1111001;
   localparam logic [6:0] S2   = 7'b0100100;
   localparam logic [6:0] S3   = 7'b0110000;
   localparam logic [6:0] S4   = 7'b0011001;
   localparam logic [6:0] S5   = 7'b0010010;
   localparam logic [6:0] S7   = 7'b1111000;
   localparam logic [6:0] DASH = 7'b0111111;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_pass = 0;

   ssd_display_arbiter_if bus ();

   ssd_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req  = 3'b000;
      reset    = 1'b0;
      repeat (2) step();
      reset    = 1'b1;
   endtask

   task automatic read_digit(input logic [3:0] an, output logic [6:0] led);
      int n = 0;
      while (bus.activate !== an && n < 40) begin
         step();
         n++;
      end
      if (bus.activate !== an) begin
         n_chk++;
         $display("FAIL read_digit timeout activate=%b want=%b", bus.activate, an);
      end
      led = bus.LED_output;
   endtask

   task automatic wait_idle_busy();
      int n = 0;
      while (bus.busy === 1'b1 && n < 60) begin
         step();
         n++;
      end
      n_chk++;
      if (bus.busy !== 1'b0)
         $display("FAIL busy_drop timeout busy=%b want=0", bus.busy);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      logic [3:0] exp_a [4];
      exp_a = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
      bus.req = 3'b000;
      reset = 1'b0;
      step();
      n_chk++;
      if (bus.grant !== 3'b000) $display("FAIL rst_grant got=%b want=000", bus.grant);
      else n_pass++;
      n_chk++;
      if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy);
      else n_pass++;
      n_chk++;
      if (bus.activate !== 4'b0111) $display("FAIL rst_act got=%b want=0111", bus.activate);
      else n_pass++;
      n_chk++;
      if (bus.LED_output !== S0) $display("FAIL rst_led got=%b want=%b", bus.LED_output, S0);
      else n_pass++;
      step();
      reset = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c % TD == 0) begin
            n_chk++;
            if (bus.activate !== exp_a[c/TD-1])
               $display("FAIL scan_act c=%0d got=%b want=%b", c, bus.activate, exp_a[c/TD-1]);
            else n_pass++;
            n_chk++;
            if (bus.LED_output !== S0 || bus.grant !== 3'b000)
               $display("FAIL scan_idle c=%0d led=%b grant=%b want=%b/000", c, bus.LED_output, bus.grant, S0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_convert();
      int n = 0;
      logic [6:0] led;
      do_reset();
      bus.val0 = 14'd1234;
      bus.req  = 3'b001;
      step();
      n_chk++;
      if (bus.grant !== 3'b001 || bus.busy !== 1'b1)
         $display("FAIL cv_grant got=%b/%b want=001/1", bus.grant, bus.busy);
      else n_pass++;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
      n_chk++;
      if (n != 14) $display("FAIL cv_busy_len got=%0d want=14", n);
      else n_pass++;
      read_digit(4'b0111, led);
      n_chk++;
      if (led !== S1) $display("FAIL cv_d3 got=%b want=%b", led, S1);
      else n_pass++;
      read_digit(4'b1011, led);
      n_chk++;
      if (led !== S2) $display("FAIL cv_d2 got=%b want=%b", led, S2);
      else n_pass++;
      read_digit(4'b1101, led);
      n_chk++;
      if (led !== S3) $display("FAIL cv_d1 got=%b want=%b", led, S3);
      else n_pass++;
      read_digit(4'b1110, led);
      n_chk++;
      if (led !== S4) $display("FAIL cv_d0 got=%b want=%b", led, S4);
      else n_pass++;
      wait_idle_busy();
      bus.req = 3'b000;
      step();
      n_chk++;
      if (bus.grant !== 3'b000) $display("FAIL cv_release got=%b want=000", bus.grant);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g [4];
      int n;
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      do_reset();
      bus.val0 = 14'd1;
      bus.val1 = 14'd2;
      bus.val2 = 14'd3;
      bus.req  = 3'b111;
      step();
      n_chk++;
      if (bus.grant !== exp_g[0]) $display("FAIL rr_g0 got=%b want=%b", bus.grant, exp_g[0]);
      else n_pass++;
      for (int k = 1; k < 4; k++) begin
         n = 0;
         while (bus.grant === exp_g[k-1] && n < 200) begin
            n++;
            step();
         end
         n_chk++;
         if (n < 14 + (HT - 1) * TD + 1)
            $display("FAIL rr_hold k=%0d got=%0d cycles want>=%0d", k, n, 14 + (HT - 1) * TD + 1);
         else n_pass++;
         n_chk++;
         if (bus.grant !== 3'b000) $display("FAIL rr_gap k=%0d got=%b want=000", k, bus.grant);
         else n_pass++;
         step();
         n_chk++;
         if (bus.grant !== exp_g[k]) $display("FAIL rr_g k=%0d got=%b want=%b", k, bus.grant, exp_g[k]);
         else n_pass++;
      end
      bus.req = 3'b000;
   endtask

   task automatic test_overflow();
      int n = 0;
      logic [6:0] led;
      logic [3:0] an [4];
      logic [6:0] exp_l [4];
      an    = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      exp_l = '{S0, S0, S4, S2};
      do_reset();
      bus.val1 = 14'd12000;
      bus.req  = 3'b010;
      step();
      n_chk++;
      if (bus.grant !== 3'b010) $display("FAIL ov_grant got=%b want=010", bus.grant);
      else n_pass++;
      wait_idle_busy();
      for (int i = 0; i < 4; i++) begin
         read_digit(an[i], led);
         n_chk++;
         if (led !== DASH) $display("FAIL ov_dash i=%0d got=%b want=%b", i, led, DASH);
         else n_pass++;
      end
      bus.val1 = 14'd42;
      while (bus.busy !== 1'b1 && n < 200) begin
         n++;
         step();
      end
      n_chk++;
      if (bus.busy !== 1'b1 || bus.grant !== 3'b010)
         $display("FAIL ov_recapture busy=%b grant=%b want=1/010", bus.busy, bus.grant);
      else n_pass++;
      wait_idle_busy();
      for (int i = 0; i < 4; i++) begin
         read_digit(an[i], led);
         n_chk++;
         if (led !== exp_l[i]) $display("FAIL ov_42 i=%0d got=%b want=%b", i, led, exp_l[i]);
         else n_pass++;
      end
      bus.req = 3'b000;
   endtask

   task automatic test_drop();
      int bad = 0;
      logic [6:0] want;
      logic [6:0] led;
      do_reset();
      bus.val0 = 14'd5;
      bus.val2 = 14'd7;
      bus.req  = 3'b001;
      step();
      wait_idle_busy();
      bus.req = 3'b101;
      repeat (6) step();
      bus.req = 3'b100;
      step();
      n_chk++;
      if (bus.grant !== 3'b000) $display("FAIL dr_gap got=%b want=000", bus.grant);
      else n_pass++;
      step();
      n_chk++;
      if (bus.grant !== 3'b100 || bus.busy !== 1'b1)
         $display("FAIL dr_grant got=%b/%b want=100/1", bus.grant, bus.busy);
      else n_pass++;
      for (int k = 0; k < 13; k++) begin
         step();
         want = (bus.activate == 4'b1110) ? S5 : S0;
         if (bus.LED_output !== want) bad++;
      end
      n_chk++;
      if (bad != 0) $display("FAIL dr_hold_digits got=%0d bad cycles want=0", bad);
      else n_pass++;
      wait_idle_busy();
      read_digit(4'b1110, led);
      n_chk++;
      if (led !== S7) $display("FAIL dr_new got=%b want=%b", led, S7);
      else n_pass++;
      bus.req = 3'b000;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.val0 = 14'd999;
      bus.req  = 3'b001;
      step();
      repeat (5) step();
      reset = 1'b0;
      #1;
      n_chk++;
      if (bus.grant !== 3'b000 || bus.busy !== 1'b0)
         $display("FAIL mid_gb got=%b/%b want=000/0", bus.grant, bus.busy);
      else n_pass++;
      n_chk++;
      if (bus.activate !== 4'b0111 || bus.LED_output !== S0)
         $display("FAIL mid_disp got=%b/%b want=0111/%b", bus.activate, bus.LED_output, S0);
      else n_pass++;
      bus.req = 3'b011;
      step();
      reset = 1'b1;
      step();
      n_chk++;
      if (bus.grant !== 3'b001) $display("FAIL mid_ptr011 got=%b want=001", bus.grant);
      else n_pass++;
      do_reset();
      bus.req = 3'b010;
      step();
      n_chk++;
      if (bus.grant !== 3'b010) $display("FAIL mid_ptr010 got=%b want=010", bus.grant);
      else n_pass++;
      bus.req = 3'b000;
   endtask

   initial begin
      bus.req  = 3'b000;
      bus.val0 = '0;
      bus.val1 = '0;
      bus.val2 = '0;
      reset    = 1'b0;
      test_reset();
      test_convert();
      test_round_robin();
      test_overflow();
      test_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
